// File: rtl/face_result_streamer_pkg.sv
// Shared types and constants for the face-result streamer: send FSM states and header layout.
package face_result_streamer_pkg;

    localparam int unsigned HDR_OVF_BIT = 7;
    localparam int unsigned HDR_CNT_W   = 7;
    localparam int unsigned MAX_DEPTH   = 127;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        REC
    } send_state_t;

    typedef logic [7:0] field_t;

    typedef struct packed {
        field_t x1;
        field_t y1;
        field_t x2;
        field_t y2;
    } face_rec_t;

    function automatic logic [7:0] make_header(input logic ovf, input logic [HDR_CNT_W-1:0] cnt);
        logic [7:0] h;
        h = {1'b0, cnt};
        h[HDR_OVF_BIT] = ovf;
        return h;
    endfunction

endpackage

// File: rtl/face_result_streamer_if.sv
// Record-input and byte-output handshake bundle between the detector, the streamer and the UART.
interface face_result_streamer_if #(
    parameter int unsigned DATA_W = 32
);
    logic              rec_valid;
    logic              rec_ready;
    logic [DATA_W-1:0] rec_data;
    logic              frame_done;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output rec_valid, rec_data, frame_done, tx_ready,
        input  rec_ready, tx_data, tx_valid
    );

    modport slave (
        input  rec_valid, rec_data, frame_done, tx_ready,
        output rec_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/face_result_streamer_result_fifo.sv
// Circular record buffer with show-ahead head; push when full and pop when empty are ignored.
module result_fifo
    import face_result_streamer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[head];

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else begin
            if (do_push) tail <= next_ptr(tail);
            if (do_pop)  head <= next_ptr(head);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[tail] <= wdata;
    end

endmodule

// File: rtl/face_result_streamer.sv
// Frame accounting, pending-frame slot and byte-serialising send FSM in front of the record FIFO.
module face_result_streamer
    import face_result_streamer_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned NUM_FIELDS     = 4,
    parameter int unsigned FIELD_W        = 8,
    parameter int unsigned DROP_WHEN_FULL = 0,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    face_result_streamer_if.slave bus,
    output logic                 busy,
    output logic [LVL_W-1:0]     fifo_level,
    output logic [15:0]          drop_count
);
    localparam int unsigned REC_W = NUM_FIELDS * FIELD_W;
    localparam int unsigned BYTES = REC_W / 8;
    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned CNT_W = LVL_W;

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("face_result_streamer: DEPTH must be within 1..%0d", MAX_DEPTH);
    end
    if (FIELD_W == 0 || (FIELD_W % 8) != 0) begin : g_bad_field_w
        $error("face_result_streamer: FIELD_W must be a non-zero multiple of 8");
    end

    send_state_t      state, state_nxt;
    logic [CNT_W-1:0] open_cnt, pend_cnt, send_cnt, close_cnt;
    logic             open_ovf, pend_ovf, send_ovf, close_ovf;
    logic             pend_valid;
    logic [IDX_W-1:0] byte_idx;
    logic             full, empty, push, drop, pop;
    logic             take_pend, take_close, last_byte;
    logic [REC_W-1:0] head;
    logic [7:0]       head_bytes [BYTES];

    assign push          = bus.rec_valid && !full;
    assign drop          = (DROP_WHEN_FULL != 0) && bus.rec_valid && full;
    assign bus.rec_ready = (DROP_WHEN_FULL != 0) ? 1'b1 : !full;
    // A record accepted alongside frame_done belongs to the frame being closed.
    assign close_cnt     = open_cnt + CNT_W'(push);
    assign close_ovf     = open_ovf | drop;
    assign last_byte     = (byte_idx == IDX_W'(BYTES - 1));
    assign busy          = (state != IDLE) || pend_valid;

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (bus.rec_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_comb begin
        for (int unsigned i = 0; i < BYTES; i++) begin
            head_bytes[i] = head[REC_W - 1 - 8 * i -: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // An idle FSM takes a closing frame directly, bypassing the pending slot, for 1-cycle latency.
    always_comb begin
        state_nxt    = state;
        take_pend    = 1'b0;
        take_close   = 1'b0;
        pop          = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        unique case (state)
            IDLE: begin
                if (pend_valid) begin
                    take_pend = 1'b1;
                    state_nxt = HDR;
                end else if (bus.frame_done) begin
                    take_close = 1'b1;
                    state_nxt  = HDR;
                end
            end
            HDR: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = make_header(send_ovf, HDR_CNT_W'(send_cnt));
                if (bus.tx_ready) state_nxt = (send_cnt != '0) ? REC : IDLE;
            end
            REC: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = head_bytes[byte_idx];
                if (bus.tx_ready && last_byte && !empty) begin
                    pop = 1'b1;
                    if (send_cnt == CNT_W'(1)) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            open_cnt   <= '0;
            open_ovf   <= 1'b0;
            pend_valid <= 1'b0;
            pend_cnt   <= '0;
            pend_ovf   <= 1'b0;
            send_cnt   <= '0;
            send_ovf   <= 1'b0;
            byte_idx   <= '0;
            drop_count <= '0;
        end else begin
            if (bus.frame_done) begin
                open_cnt <= '0;
                open_ovf <= 1'b0;
            end else begin
                if (push) open_cnt <= open_cnt + CNT_W'(1);
                if (drop) open_ovf <= 1'b1;
            end

            if (bus.frame_done && !take_close) begin
                if (pend_valid && !take_pend) begin
                    pend_cnt <= pend_cnt + close_cnt;
                    pend_ovf <= 1'b1;
                end else begin
                    pend_valid <= 1'b1;
                    pend_cnt   <= close_cnt;
                    pend_ovf   <= close_ovf;
                end
            end else if (take_pend) begin
                pend_valid <= 1'b0;
            end

            if (take_pend) begin
                send_cnt <= pend_cnt;
                send_ovf <= pend_ovf;
            end else if (take_close) begin
                send_cnt <= close_cnt;
                send_ovf <= close_ovf;
            end else if (pop) begin
                send_cnt <= send_cnt - CNT_W'(1);
            end

            if (take_pend || take_close) byte_idx <= '0;
            else if (state == REC && bus.tx_ready) byte_idx <= last_byte ? '0 : byte_idx + IDX_W'(1);

            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_face_result_streamer.sv
// Scoreboard bench: a frame-level model queues expected UART bytes, per-instance monitors pop and compare.
module tb_face_result_streamer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NB    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned LW    = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    face_result_streamer_if #(.DATA_W(DW)) a_if ();
    face_result_streamer_if #(.DATA_W(DW)) b_if ();

    logic          busy_a, busy_b;
    logic [LW-1:0] lvl_a, lvl_b;
    logic [15:0]   drops_a, drops_b;

    face_result_streamer #(.DEPTH(DEPTH), .NUM_FIELDS(4), .FIELD_W(8), .DROP_WHEN_FULL(0)) dut_a (
        .clock(clock), .reset(reset), .bus(a_if), .busy(busy_a), .fifo_level(lvl_a), .drop_count(drops_a));
    face_result_streamer #(.DEPTH(DEPTH), .NUM_FIELDS(4), .FIELD_W(8), .DROP_WHEN_FULL(1)) dut_b (
        .clock(clock), .reset(reset), .bus(b_if), .busy(busy_b), .fifo_level(lvl_b), .drop_count(drops_b));

    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [8:0]  exp_a[$], exp_b[$];
    logic [31:0] open_a[$], open_b[$], held_a[$];
    bit          open_ovf_a = 0, open_ovf_b = 0, held_ovf_a = 0, held_valid_a = 0;
    int unsigned hdr_seen_a = 0, hdr_seen_b = 0, hdr_exp_a = 0, hdr_exp_b = 0;
    int unsigned stored_a = 0, stored_b = 0, rb_a = 0, rb_b = 0, drops_model_b = 0;
    int unsigned txm_a = 1, txm_b = 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    function automatic logic get_ready(input bit b);
        return b ? b_if.rec_ready : a_if.rec_ready;
    endfunction

    task automatic set_rec(input bit b, input logic v, input logic [31:0] d);
        if (b) begin b_if.rec_valid = v; b_if.rec_data = d; end
        else   begin a_if.rec_valid = v; a_if.rec_data = d; end
    endtask

    task automatic set_fd(input bit b, input logic v);
        if (b) b_if.frame_done = v;
        else   a_if.frame_done = v;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drop-on-full instance keeps a record only while fewer than DEPTH are stored.
    task automatic model_accept(input bit b, input logic [31:0] d);
        if (b) begin
            if (stored_b >= DEPTH) begin open_ovf_b = 1; drops_model_b++; end
            else begin open_b.push_back(d); stored_b++; end
        end else begin
            open_a.push_back(d);
            stored_a++;
        end
    endtask

    task automatic emit_frame(input bit b, input bit ovf, input logic [31:0] recs[$]);
        logic [7:0]  hdr;
        logic [31:0] r;
        hdr = 8'((ovf ? 128 : 0) + recs.size());
        if (b) begin exp_b.push_back({1'b1, hdr}); hdr_exp_b++; end
        else   begin exp_a.push_back({1'b1, hdr}); hdr_exp_a++; end
        foreach (recs[k]) begin
            r = recs[k];
            for (int unsigned i = 0; i < NB; i++) begin
                if (b) exp_b.push_back({1'b0, 8'((r >> (8 * (NB - 1 - i))) & 32'hFF)});
                else   exp_a.push_back({1'b0, 8'((r >> (8 * (NB - 1 - i))) & 32'hFF)});
            end
        end
    endtask

    task automatic push_rec(input bit b, input logic [31:0] d);
        int unsigned n;
        n = 0;
        set_rec(b, 1'b1, d);
        while (get_ready(b) !== 1'b1 && n < 3000) begin tick(); n++; end
        if (n >= 3000) begin
            timeout("push_wait");
            set_rec(b, 1'b0, '0);
            return;
        end
        model_accept(b, d);
        tick();
        set_rec(b, 1'b0, '0);
    endtask

    // hold=1 keeps the frame in a waiting buffer; a further held close merges into it with ovf set.
    task automatic close_frame(input bit b, input bit hold, input bit with_rec, input logic [31:0] d);
        int unsigned n;
        logic [31:0] fr[$];
        bit          fo;
        n = 0;
        if (!hold) begin
            while ((b ? (hdr_seen_b < hdr_exp_b) : (hdr_seen_a < hdr_exp_a)) && n < 3000) begin tick(); n++; end
            if (n >= 3000) timeout("frame_gate");
        end
        if (with_rec && get_ready(b) !== 1'b1) begin
            push_rec(b, d);
            with_rec = 0;
        end
        if (with_rec) begin
            set_rec(b, 1'b1, d);
            model_accept(b, d);
        end
        set_fd(b, 1'b1);
        tick();
        set_rec(b, 1'b0, '0);
        set_fd(b, 1'b0);
        if (b) begin fr = open_b; fo = open_ovf_b; open_b.delete(); open_ovf_b = 0; end
        else   begin fr = open_a; fo = open_ovf_a; open_a.delete(); open_ovf_a = 0; end
        if (!b && held_valid_a) begin
            foreach (fr[i]) held_a.push_back(fr[i]);
            held_ovf_a = 1;
        end else if (!b && hold) begin
            held_a = fr;
            held_ovf_a = fo;
            held_valid_a = 1;
        end else begin
            emit_frame(b, fo, fr);
        end
    endtask

    task automatic flush_held_a();
        emit_frame(0, held_ovf_a, held_a);
        held_a.delete();
        held_valid_a = 0;
    endtask

    task automatic wait_idle(input bit b);
        int unsigned n;
        n = 0;
        while ((b ? (exp_b.size() != 0 || busy_b) : (exp_a.size() != 0 || busy_a)) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) timeout(b ? "idle_b" : "idle_a");
        if (b) chk("level_idle_b", 32'(lvl_b), stored_b);
        else   chk("level_idle_a", 32'(lvl_a), stored_a);
    endtask

    task automatic take_byte(input bit b, input logic [7:0] d);
        logic [8:0] e;
        if ((b ? exp_b.size() : exp_a.size()) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte_%s: got 0x%02h, no byte expected", b ? "b" : "a", d);
            return;
        end
        e = b ? exp_b.pop_front() : exp_a.pop_front();
        chk({e[8] ? "header" : "record_byte", b ? "_b" : "_a"}, 32'(d), 32'(e[7:0]));
        if (e[8]) begin
            if (b) begin hdr_seen_b++; rb_b = 0; end
            else   begin hdr_seen_a++; rb_a = 0; end
        end else if (b) begin
            rb_b++;
            if (rb_b == NB) begin rb_b = 0; stored_b--; end
        end else begin
            rb_a++;
            if (rb_a == NB) begin rb_a = 0; stored_a--; end
        end
    endtask

    bit         stall_a = 0, stall_b = 0;
    logic [7:0] hold_a, hold_b;

    always @(negedge clock) begin
        if (reset) begin
            stall_a = 0;
        end else begin
            if (stall_a) begin
                chk("stall_valid_a", 32'(a_if.tx_valid), 32'd1);
                chk("stall_data_a", 32'(a_if.tx_data), 32'(hold_a));
            end
            if (a_if.tx_valid && a_if.tx_ready) take_byte(0, a_if.tx_data);
            stall_a = a_if.tx_valid && !a_if.tx_ready;
            hold_a  = a_if.tx_data;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            stall_b = 0;
        end else begin
            if (stall_b) begin
                chk("stall_valid_b", 32'(b_if.tx_valid), 32'd1);
                chk("stall_data_b", 32'(b_if.tx_data), 32'(hold_b));
            end
            if (b_if.tx_valid && b_if.tx_ready) take_byte(1, b_if.tx_data);
            stall_b = b_if.tx_valid && !b_if.tx_ready;
            hold_b  = b_if.tx_data;
        end
    end

    always @(posedge clock) begin
        #1;
        a_if.tx_ready = (txm_a == 2) ? 1'($urandom_range(0, 1)) : (txm_a == 1);
        b_if.tx_ready = (txm_b == 2) ? 1'($urandom_range(0, 1)) : (txm_b == 1);
    end

    task automatic random_frames(input int unsigned nframes, input bit fixed4);
        int unsigned n, g;
        bit          closed;
        logic [31:0] d;
        for (int unsigned f = 0; f < nframes; f++) begin
            n = fixed4 ? 4 : $urandom_range(0, 4);
            closed = 0;
            for (int unsigned k = 0; k < n; k++) begin
                d = fixed4 ? 32'((f * 4 + k) * 32'h01010101) : $urandom;
                if (k == n - 1 && $urandom_range(0, 1) == 1) begin
                    close_frame(0, 0, 1, d);
                    closed = 1;
                end else begin
                    push_rec(0, d);
                    g = $urandom_range(0, 2);
                    repeat (g) tick();
                end
            end
            if (!closed) close_frame(0, 0, 0, '0);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_if.rec_valid = 0; a_if.rec_data = '0; a_if.frame_done = 0; a_if.tx_ready = 0;
        b_if.rec_valid = 0; b_if.rec_data = '0; b_if.frame_done = 0; b_if.tx_ready = 0;
        repeat (3) @(posedge clock);
        #1 reset = 0;

        chk("reset_rec_ready_a", 32'(a_if.rec_ready), 32'd1);
        chk("reset_tx_valid_a", 32'(a_if.tx_valid), 32'd0);
        chk("reset_tx_data_a", 32'(a_if.tx_data), 32'd0);
        chk("reset_busy_a", 32'(busy_a), 32'd0);
        chk("reset_level_a", 32'(lvl_a), 32'd0);
        chk("reset_drops_a", 32'(drops_a), 32'd0);
        chk("reset_rec_ready_b", 32'(b_if.rec_ready), 32'd1);
        chk("reset_tx_valid_b", 32'(b_if.tx_valid), 32'd0);
        chk("reset_busy_b", 32'(busy_b), 32'd0);
        chk("reset_drops_b", 32'(drops_b), 32'd0);
        tick();

        // Empty frame: header 0x00 offered the cycle after frame_done, busy drops after accept.
        close_frame(0, 0, 0, '0);
        chk("zero_frame_tx_valid", 32'(a_if.tx_valid), 32'd1);
        chk("zero_frame_tx_data", 32'(a_if.tx_data), 32'h00);
        chk("zero_frame_busy", 32'(busy_a), 32'd1);
        tick();
        chk("zero_frame_busy_after", 32'(busy_a), 32'd0);
        chk("zero_frame_valid_after", 32'(a_if.tx_valid), 32'd0);

        push_rec(0, 32'h01020304);
        push_rec(0, 32'h05060708);
        close_frame(0, 0, 0, '0);
        wait_idle(0);

        txm_a = 2;
        push_rec(0, 32'h01020304);
        push_rec(0, 32'h05060708);
        close_frame(0, 0, 0, '0);
        wait_idle(0);

        // Output stalled: frame 1 is transmitting, frames 2 and 3 close behind it and merge.
        txm_a = 0;
        repeat (3) tick();
        push_rec(0, 32'h11121314);
        push_rec(0, 32'h21222324);
        close_frame(0, 0, 0, '0);
        push_rec(0, 32'h31323334);
        close_frame(0, 1, 0, '0);
        push_rec(0, 32'h41424344);
        close_frame(0, 1, 0, '0);
        tick();
        chk("merge_level", 32'(lvl_a), stored_a);
        chk("merge_rec_ready", 32'(a_if.rec_ready), 32'(stored_a < DEPTH));
        chk("merge_busy", 32'(busy_a), 32'd1);
        flush_held_a();
        txm_a = 2;
        wait_idle(0);

        random_frames(5, 1);
        wait_idle(0);
        random_frames(14, 0);
        wait_idle(0);
        chk("drops_mode0", 32'(drops_a), 32'd0);

        // Drop-on-full instance: 6 records into a 4-deep buffer.
        txm_b = 1;
        for (int unsigned k = 0; k < 6; k++) begin
            push_rec(1, 32'hA0B0C0D0 + 32'(k));
            if (k == 3) begin
                chk("full_level_b", 32'(lvl_b), stored_b);
                chk("full_rec_ready_b", 32'(b_if.rec_ready), 32'd1);
            end
        end
        close_frame(1, 0, 0, '0);
        wait_idle(1);
        chk("drop_count_b", 32'(drops_b), drops_model_b);
        push_rec(1, 32'h0D0E0F10);
        close_frame(1, 0, 1, 32'h11121314);
        txm_b = 2;
        wait_idle(1);
        chk("drop_count_b_after", 32'(drops_b), drops_model_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
